multicycle_controller: RTL and testbench

- Moore-style FSM that sequences the shared-memory multicycle MIPS datapath: instruction fetch, decode, address generation, memory access, execute and writeback.
- Handles lw, sw, R-type (add/sub/and/or/slt), beq, addi and j.
- Replaces the single-cycle control pair in the multicycle CPU top. Instantiates the existing aludec for ALU function decode.
- One unified memory port with a ready handshake.

---
 rtl/mips_pkg.sv | 58 +++++
 rtl/aludec.sv | 30 +++
 rtl/multicycle_controller.sv | 159 +++++++++++++++
 tb/tb_multicycle_controller.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the multicycle MIPS control path
package mips_pkg;

   // Opcodes (instruction[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // R-type function codes (instruction[5:0])
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // ALU function codes
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // ALU operation class handed from the FSM to aludec
   typedef logic [1:0] aluop_t;
   localparam aluop_t ALUOP_ADD   = 2'b00;
   localparam aluop_t ALUOP_SUB   = 2'b01;
   localparam aluop_t ALUOP_FUNCT = 2'b10;

   // ALU B-operand select
   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_BRIMM = 2'b11;

   // Next-PC select
   localparam logic [1:0] PC_ALURES = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   // FSM state encoding (4-bit; codes 12..15 are unused)
   typedef logic [3:0] state_t;
   localparam state_t S_FETCH   = 4'd0;
   localparam state_t S_DECODE  = 4'd1;
   localparam state_t S_MEMADR  = 4'd2;
   localparam state_t S_MEMRD   = 4'd3;
   localparam state_t S_MEMWB   = 4'd4;
   localparam state_t S_MEMWR   = 4'd5;
   localparam state_t S_EXECUTE = 4'd6;
   localparam state_t S_ALUWB   = 4'd7;
   localparam state_t S_BRANCH  = 4'd8;
   localparam state_t S_ADDIEX  = 4'd9;
   localparam state_t S_ADDIWB  = 4'd10;
   localparam state_t S_JUMP    = 4'd11;

endpackage

// File: rtl/aludec.sv
// rtl/aludec.sv - ALU function decode from aluop and R-type funct
module aludec
   import mips_pkg::*;
(
   input  logic [5:0] funct,
   input  aluop_t     aluop,
   output logic [2:0] alucontrol
);

   // Fixed add/sub for address and branch math, funct-driven for R-type
   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         ALUOP_ADD: alucontrol = ALU_ADD;
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  alucontrol = ALU_ADD;
               FN_SUB:  alucontrol = ALU_SUB;
               FN_AND:  alucontrol = ALU_AND;
               FN_OR:   alucontrol = ALU_OR;
               FN_SLT:  alucontrol = ALU_SLT;
               default: alucontrol = ALU_ADD;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM sequencing the multicycle MIPS datapath
module multicycle_controller
   import mips_pkg::*;
#(
   parameter int MEM_WAIT_EN = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic       pcen,
   output logic [2:0] alucontrol,
   output logic       illegal
);

   state_t state;
   state_t state_nx;
   logic   set_illegal;
   logic   mem_ok;
   aluop_t aluop;
   logic   pcwrite;
   logic   branch;
   logic   memwrite_s;
   logic   irwrite_s;
   logic   regwrite_s;

   // With waiting disabled the memory is assumed to complete every cycle
   assign mem_ok = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

   // Next-state selection; an unknown opcode in DECODE aborts back to FETCH
   always_comb begin
      state_nx    = S_FETCH;
      set_illegal = 1'b0;
      case (state)
         S_FETCH:   state_nx = mem_ok ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_nx = S_MEMADR;
               OP_RTYPE:     state_nx = S_EXECUTE;
               OP_BEQ:       state_nx = S_BRANCH;
               OP_ADDI:      state_nx = S_ADDIEX;
               OP_J:         state_nx = S_JUMP;
               default: begin
                  state_nx    = S_FETCH;
                  set_illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR:  state_nx = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   state_nx = mem_ok ? S_MEMWB : S_MEMRD;
         S_MEMWB:   state_nx = S_FETCH;
         S_MEMWR:   state_nx = mem_ok ? S_FETCH : S_MEMWR;
         S_EXECUTE: state_nx = S_ALUWB;
         S_ALUWB:   state_nx = S_FETCH;
         S_BRANCH:  state_nx = S_FETCH;
         S_ADDIEX:  state_nx = S_ADDIWB;
         S_ADDIWB:  state_nx = S_FETCH;
         S_JUMP:    state_nx = S_FETCH;
         default:   state_nx = S_FETCH;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_FETCH;
      else          state <= state_nx;
   end

   // Sticky illegal-opcode flag, cleared only by reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)         illegal <= 1'b0;
      else if (set_illegal) illegal <= 1'b1;
   end

   // Moore output decode; FETCH strobes additionally follow memory completion
   always_comb begin
      iord       = 1'b0;
      memwrite_s = 1'b0;
      irwrite_s  = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite_s = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = SRCB_REG;
      pcsrc      = PC_ALURES;
      aluop      = ALUOP_ADD;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      case (state)
         S_FETCH: begin
            alusrcb   = SRCB_FOUR;
            irwrite_s = mem_ok;
            pcwrite   = mem_ok;
         end
         S_DECODE:  alusrcb = SRCB_BRIMM;
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
         end
         S_MEMRD:   iord = 1'b1;
         S_MEMWB: begin
            memtoreg   = 1'b1;
            regwrite_s = 1'b1;
         end
         S_MEMWR: begin
            iord       = 1'b1;
            memwrite_s = 1'b1;
         end
         S_EXECUTE: begin
            alusrca = 1'b1;
            aluop   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            regdst     = 1'b1;
            regwrite_s = 1'b1;
         end
         S_BRANCH: begin
            alusrca = 1'b1;
            aluop   = ALUOP_SUB;
            pcsrc   = PC_ALUOUT;
            branch  = 1'b1;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
         end
         S_ADDIWB:  regwrite_s = 1'b1;
         S_JUMP: begin
            pcsrc   = PC_JUMP;
            pcwrite = 1'b1;
         end
         default: ;
      endcase
   end

   // Write strobes are masked while reset is held so nothing commits mid-reset
   assign memwrite = memwrite_s & reset_n;
   assign irwrite  = irwrite_s & reset_n;
   assign regwrite = regwrite_s & reset_n;
   assign pcen     = (pcwrite | (branch & zero)) & reset_n;

   aludec u_aludec (
      .funct      (funct),
      .aluop      (aluop),
      .alucontrol (alucontrol)
   );

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized self-checking bench for multicycle_controller
module tb_multicycle_controller;

   localparam logic [5:0] T_LW = 6'b100011, T_SW = 6'b101011, T_R = 6'b000000;
   localparam logic [5:0] T_BEQ = 6'b000100, T_ADDI = 6'b001000, T_J = 6'b000010;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] op, funct;
   logic       zero, mem_ready;
   logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;

   typedef struct packed {
      logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
      logic [1:0] alusrcb, pcsrc;
      logic       pcen;
      logic [2:0] alucontrol;
      logic       illegal;
   } ctl_t;

   typedef struct {
      logic  mr;
      logic  z;
      ctl_t  exp;
      string tag;
   } cyc_t;

   cyc_t q[$];
   int   checks = 0;
   int   errors = 0;
   logic ill_m;
   ctl_t obs;

   assign obs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                 alusrcb, pcsrc, pcen, alucontrol, illegal};

   multicycle_controller dut (
      .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
      .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
      .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen), .alucontrol(alucontrol),
      .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input ctl_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Quiet cycle: nothing asserted, ALU adding, current sticky flag
   function automatic ctl_t base();
      ctl_t c;
      c = '0;
      c.alucontrol = 3'b010;
      c.illegal    = ill_m;
      return c;
   endfunction

   function automatic logic [2:0] rfunc(input logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(input string tag, input logic mr, input logic z, input ctl_t c);
      cyc_t e;
      e.mr = mr; e.z = z; e.exp = c; e.tag = tag;
      q.push_back(e);
   endtask

   // Expected cycle-by-cycle trace of one instruction; sf/sm are stall counts
   task automatic build(input logic [5:0] o, input logic [5:0] f, input logic z,
                        input int sf, input int sm);
      ctl_t c;
      for (int i = 0; i <= sf; i++) begin
         c = base(); c.alusrcb = 2'b01;
         c.irwrite = (i == sf); c.pcen = (i == sf);
         push("fetch", (i == sf), rb(), c);
      end
      c = base(); c.alusrcb = 2'b11;
      push("decode", rb(), rb(), c);
      if (o == T_LW || o == T_SW) begin
         c = base(); c.alusrca = 1'b1; c.alusrcb = 2'b10;
         push("memadr", rb(), rb(), c);
         for (int i = 0; i <= sm; i++) begin
            c = base(); c.iord = 1'b1; c.memwrite = (o == T_SW);
            push((o == T_SW) ? "memwr" : "memrd", (i == sm), rb(), c);
         end
         if (o == T_LW) begin
            c = base(); c.memtoreg = 1'b1; c.regwrite = 1'b1;
            push("memwb", rb(), rb(), c);
         end
      end else if (o == T_R) begin
         c = base(); c.alusrca = 1'b1; c.alucontrol = rfunc(f);
         push("execute", rb(), rb(), c);
         c = base(); c.regdst = 1'b1; c.regwrite = 1'b1;
         push("aluwb", rb(), rb(), c);
      end else if (o == T_BEQ) begin
         c = base(); c.alusrca = 1'b1; c.alucontrol = 3'b110;
         c.pcsrc = 2'b01; c.pcen = z;
         push("branch", rb(), z, c);
      end else if (o == T_ADDI) begin
         c = base(); c.alusrca = 1'b1; c.alusrcb = 2'b10;
         push("addiex", rb(), rb(), c);
         c = base(); c.regwrite = 1'b1;
         push("addiwb", rb(), rb(), c);
      end else if (o == T_J) begin
         c = base(); c.pcsrc = 2'b10; c.pcen = 1'b1;
         push("jump", rb(), rb(), c);
      end else begin
         ill_m = 1'b1;
      end
   endtask

   // Entered and left at posedge+1; abort pulls reset during the final cycle
   task automatic instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                        input int sf, input int sm, input bit abort);
      cyc_t e;
      ctl_t c;
      op = o; funct = f;
      build(o, f, z, sf, sm);
      while (q.size() > 0) begin
         e = q.pop_front();
         mem_ready = e.mr; zero = e.z;
         #1;
         check(e.tag, e.exp);
         if (abort && q.size() == 0) begin
            reset_n = 1'b0; mem_ready = 1'b1;
            ill_m = 1'b0;
            #1;
            c = base(); c.alusrcb = 2'b01;
            check("reset_mid", c);
            @(posedge clk); #1;
            check("reset_hold", c);
            reset_n = 1'b1;
         end else begin
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      ctl_t c;
      logic [5:0] ro, rf;
      reset_n = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
      ill_m = 1'b0;
      #2;
      c = base(); c.alusrcb = 2'b01;
      check("reset_init", c);
      @(posedge clk); #1;
      check("reset_init_hold", c);
      reset_n = 1'b1;

      instr(T_LW,   6'd0,      1'b0, 0, 0, 1'b0);
      instr(T_SW,   6'd0,      1'b0, 0, 2, 1'b0);
      instr(T_R,    6'b101010, 1'b0, 0, 0, 1'b0);
      instr(T_BEQ,  6'd0,      1'b1, 0, 0, 1'b0);
      instr(T_BEQ,  6'd0,      1'b0, 0, 0, 1'b0);
      instr(T_J,    6'd0,      1'b0, 0, 0, 1'b0);
      instr(6'b111111, 6'd0,   1'b0, 0, 0, 1'b0);
      instr(T_ADDI, 6'd0,      1'b0, 1, 0, 1'b0);
      instr(T_R,    6'b111000, 1'b0, 0, 0, 1'b0);
      instr(T_LW,   6'd0,      1'b0, 1, 1, 1'b1);
      instr(T_ADDI, 6'd0,      1'b0, 0, 0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 6))
            0: ro = T_LW;
            1: ro = T_SW;
            2: ro = T_R;
            3: ro = T_BEQ;
            4: ro = T_ADDI;
            5: ro = T_J;
            default: ro = 6'($urandom);
         endcase
         case ($urandom_range(0, 5))
            0: rf = 6'b100000;
            1: rf = 6'b100010;
            2: rf = 6'b100100;
            3: rf = 6'b100101;
            4: rf = 6'b101010;
            default: rf = 6'($urandom);
         endcase
         instr(ro, rf, rb(), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
